serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request one subtraction; honoured only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled on the accepted start.
REQ-007 SHALL have port bin  input  1  borrow-in; sampled on the accepted start.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  single-cycle pulse when the result is valid.
REQ-010 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  final borrow-out of the MSB stage.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: on start=1, SHALL load a, b and bin into shift registers and a borrow flop, clear the bit counter, and enter RUN; start=0 SHALL leave it in IDLE.
REQ-014 RUN: each cycle SHALL apply the LSB of each operand shift register and the borrow flop to one full-subtractor cell (d = x^y^z, bo = (~x&y) | (~(x^y)&z)).
REQ-015 RUN: each cycle SHALL shift d into the diff register at the MSB end, shift both operands right, and store bo in the borrow flop.
REQ-016 SHALL leave RUN for DONE after exactly WIDTH RUN cycles; the counter SHALL be $clog2(WIDTH) bits wide and SHALL compare against WIDTH-1.
REQ-017 DONE: SHALL assert done for exactly one cycle, drive bout from the borrow flop, then return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge t SHALL give done=1 in the cycle after edge t+WIDTH, i.e. WIDTH+2 cycles start-to-start minimum.
REQ-019 start asserted in RUN or DONE SHALL be ignored; the current operation and its operands SHALL NOT be disturbed.
REQ-020 diff and bout SHALL hold their last result from DONE until the next accepted start; they are undefined-but-stable during RUN.
REQ-021 Input changes on a, b or bin after acceptance SHALL NOT affect the result.

Reset
REQ-022 rst=1 at any edge, including mid-RUN, SHALL force IDLE and abort any operation without producing a done pulse.
REQ-023 Reset values SHALL be busy=0, done=0, diff=0, bout=0, counter=0, borrow flop=0, and ovf=0 when present.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 SHALL support the macro SERIAL_SUB_OVF_EN.
REQ-026 With SERIAL_SUB_OVF_EN defined, SHALL add port ovf (output, 1 bit): the signed two's-complement overflow, equal to the borrow into the MSB stage XOR bout; it SHALL be valid and held with the same rules as diff and bout.
REQ-027 With SERIAL_SUB_OVF_EN undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 A shared package serial_sub_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE, 2-bit encoding) and the default WIDTH constant.
REQ-029 The one-bit subtract SHALL be a separate sub-module fs_cell (inputs x, y, z; outputs d, bo), purely combinational and instantiated once.

Verification (WIDTH=8)
REQ-030 a=0x05, b=0x03, bin=0, start pulse -> done one cycle after edge t+8, diff=0x02, bout=0, busy high for 8 cycles.
REQ-031 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-032 Accept a=0x10, b=0x01, then at RUN cycle 3 drive start=1 with a=0xFF, b=0xFF -> exactly one done, diff=0x0F, bout=0.
REQ-033 Assert rst in RUN cycle 4 -> next cycle busy=0, done=0, diff=0x00; no done pulse for 12 cycles.
REQ-034 With SERIAL_SUB_OVF_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
REQ-035 Issue start again one cycle after done -> accepted, second result correct, done pulses spaced WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor controller.
//   WIDTH_DEFAULT : default operand width
//   state_t       : FSM state encoding (IDLE / RUN / DONE, 2 bits)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// -----------------------------------------------------------------------------
// fs_cell
// One-bit full subtractor, purely combinational: computes x - y - z.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   z  : borrow in
//   d  : difference bit
//   bo : borrow out
// -----------------------------------------------------------------------------
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtractor: computes a - b - bin (mod 2^WIDTH) one bit per clock,
// LSB first, through a single fs_cell.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request a subtraction (accepted only in IDLE)
//   a, b  : minuend / subtrahend, sampled on accepted start
//   bin   : borrow in, sampled on accepted start
//   busy  : high while the serial subtraction runs
//   done  : one-cycle pulse when diff/bout (and ovf) are valid
//   diff  : result, held from DONE until the next accepted start
//   bout  : borrow out of the MSB stage, held like diff
//   ovf   : (SERIAL_SUB_OVF_EN only) signed overflow, held like diff
// -----------------------------------------------------------------------------
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             w_d;
    logic             w_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    fs_cell u_fs_cell (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .z  (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    // Control, result and borrow state (all cleared by reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB end so that after WIDTH
                    // shifts bit 0 of the result sits in diff[0].
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
`ifdef SERIAL_SUB_OVF_EN
                        // r_borrow is the borrow into the MSB stage here.
                        r_ovf   <= r_borrow ^ w_bo;
`endif
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Operand shift registers: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start && !rst) begin
            r_a <= a;
            r_b <= b;
        end else if (r_state == RUN) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    // The borrow flop keeps the final borrow untouched until the next start.
    assign bout = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
// Self-checking bench for serial_sub_ctrl (WIDTH=8). Expected results come
// from an arithmetic reference model and travel through a scoreboard queue.
// Define SERIAL_SUB_OVF_EN to include the ovf port and its checks.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int   n_vec    = 0;
    int   n_mis    = 0;
    int   cyc      = 0;
    int   done_cyc = -1;
    int   d1;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic binv);
        exp_t       e;
        logic [W:0] full;
        full = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cyc = cyc;
            if (q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after done.
    // poke >= 0 drives a conflicting start in that RUN cycle.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic binv, input int poke);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = binv;
        q.push_back(model(av, bv, binv));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = bv ^ 8'h5A;
        bin   = ~binv;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("busy_run", 32'(busy), 32'(1));
            check("done_run", 32'(done), 32'(0));
            if (k == poke) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'(1));
        check("busy_done", 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("done_clear", 32'(done), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start held high: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h03;
        bin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'(0));
`endif
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Basic and back-to-back operations.
        do_op(8'h05, 8'h03, 1'b0, -1);
        d1 = done_cyc;
        do_op(8'h03, 8'h05, 1'b0, -1);
        check("b2b_spacing", 32'(done_cyc - d1), 32'(W + 2));
        do_op(8'h00, 8'h00, 1'b1, -1);

        // Conflicting start in RUN cycle 3 is ignored.
        do_op(8'h10, 8'h01, 1'b0, 2);
        repeat (3) begin
            @(negedge clk);
            check("no_extra_busy", 32'(busy), 32'(0));
        end

        // Boundaries.
        do_op(8'hFF, 8'hFF, 1'b1, -1);
        do_op(8'h00, 8'hFF, 1'b0, -1);
        do_op(8'hFF, 8'h00, 1'b0, -1);
`ifdef SERIAL_SUB_OVF_EN
        do_op(8'h80, 8'h01, 1'b0, -1);
        do_op(8'h7F, 8'h01, 1'b0, -1);
        do_op(8'h7F, 8'hFF, 1'b0, -1);
`endif

        // Random operands.
        for (int i = 0; i < 6; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), -1);

        // Reset in RUN cycle 4 aborts without a done pulse.
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h11;
        bin   = 1'b0;
        q.push_back(model(8'h55, 8'h11, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_diff", 32'(diff), 32'(0));
        check("abort_bout", 32'(bout), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'(0));
        end

        // Operation after abort still works.
        do_op(8'h3C, 8'h0F, 1'b1, -1);

        check("queue_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
